// File: rtl/pong_game_logic.sv
// Pong game-state engine: START/PLAY/GAMEOVER control, per-frame ball motion
// with wall and paddle bounces, and player paddle movement. All outputs are registered.
module pong_game_logic #(
  parameter int unsigned FIELD_W      = 500,
  parameter int unsigned BALL_W       = 10,
  parameter int unsigned BALL_H       = 10,
  parameter int unsigned PADDLE_W     = 50,
  parameter int unsigned PADDLE_Y     = 460,
  parameter int unsigned BALL_SPEED   = 2,
  parameter int unsigned PADDLE_SPEED = 4,
  parameter int unsigned BALL_X0      = 245,
  parameter int unsigned BALL_Y0      = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  output logic [8:0] p1_paddle_x,
  output logic [8:0] p1_paddle_y,
  output logic [8:0] ball_x,
  output logic [8:0] ball_y,
  output logic       draw_start,
  output logic       draw_gameover,
  output logic [7:0] hits
);

  // 10-bit constants so every sum and compare is free of 9-bit wrap
  localparam logic [9:0] FW   = 10'(FIELD_W);
  localparam logic [9:0] BW   = 10'(BALL_W);
  localparam logic [9:0] BH   = 10'(BALL_H);
  localparam logic [9:0] PW   = 10'(PADDLE_W);
  localparam logic [9:0] PY   = 10'(PADDLE_Y);
  localparam logic [9:0] BS   = 10'(BALL_SPEED);
  localparam logic [9:0] PS   = 10'(PADDLE_SPEED);
  localparam logic [8:0] PX0  = 9'((FIELD_W - PADDLE_W) / 2);
  localparam logic [8:0] BX0  = 9'(BALL_X0);
  localparam logic [8:0] BY0  = 9'(BALL_Y0);

  typedef enum logic [1:0] {S_START, S_PLAY, S_GAMEOVER} state_t;

  state_t      state_q;
  logic        btn_start_q;
  logic [8:0]  paddle_q, ball_x_q, ball_y_q;
  logic        dx_pos_q, dy_pos_q;
  logic [7:0]  hits_q;
  logic        draw_start_q, draw_gameover_q;

  logic [8:0]  paddle_d, ball_x_d, ball_y_d;
  logic        dx_pos_d, dy_pos_d;
  logic        hit, miss;
  logic [9:0]  px, bx, by, nx, ny, psum;
  logic        start_edge, restart;

  assign start_edge = btn_start & ~btn_start_q;
  assign restart    = reset | ((state_q == S_GAMEOVER) & start_edge);

  // Candidate post-tick positions and directions from pre-tick state
  always_comb begin
    px       = {1'b0, paddle_q};
    bx       = {1'b0, ball_x_q};
    by       = {1'b0, ball_y_q};
    nx       = '0;
    ny       = '0;
    psum     = px + PS;
    paddle_d = paddle_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dx_pos_d = dx_pos_q;
    dy_pos_d = dy_pos_q;
    hit      = 1'b0;
    miss     = 1'b0;

    if (btn_left && !btn_right)
      paddle_d = (px < PS) ? '0 : 9'(px - PS);
    else if (btn_right && !btn_left)
      paddle_d = (psum > FW - PW) ? 9'(FW - PW) : 9'(psum);

    if (dx_pos_q) begin
      nx = bx + BS;
      if (nx + BW >= FW) begin
        ball_x_d = 9'(FW - BW);
        dx_pos_d = 1'b0;
      end else begin
        ball_x_d = 9'(nx);
      end
    end else if (bx < BS) begin
      ball_x_d = '0;
      dx_pos_d = 1'b1;
    end else begin
      ball_x_d = 9'(bx - BS);
    end

    if (!dy_pos_q) begin
      if (by < BS) begin
        ball_y_d = '0;
        dy_pos_d = 1'b1;
      end else begin
        ball_y_d = 9'(by - BS);
      end
    end else begin
      ny = by + BS;
      if (ny + BH < PY) begin
        ball_y_d = 9'(ny);
      end else if ((bx + BW >= px) && (bx <= px + PW)) begin
        hit      = 1'b1;
        ball_y_d = 9'(PY - BH);
        dy_pos_d = 1'b0;
      end else begin
        miss     = 1'b1;
      end
    end
  end

  // Game FSM and registered game state; reset and GAMEOVER restart share the reinit path
  always_ff @(posedge clk) begin
    if (restart) begin
      state_q         <= S_START;
      btn_start_q     <= 1'b0;
      paddle_q        <= PX0;
      ball_x_q        <= BX0;
      ball_y_q        <= BY0;
      dx_pos_q        <= 1'b1;
      dy_pos_q        <= 1'b1;
      hits_q          <= '0;
      draw_start_q    <= 1'b1;
      draw_gameover_q <= 1'b0;
    end else begin
      btn_start_q <= btn_start;
      case (state_q)
        S_START: begin
          if (start_edge) begin
            state_q      <= S_PLAY;
            draw_start_q <= 1'b0;
          end
        end
        S_PLAY: begin
          if (frame_tick) begin
            if (miss) begin
              state_q         <= S_GAMEOVER;
              draw_gameover_q <= 1'b1;
            end else begin
              paddle_q <= paddle_d;
              ball_x_q <= ball_x_d;
              ball_y_q <= ball_y_d;
              dx_pos_q <= dx_pos_d;
              dy_pos_q <= dy_pos_d;
              if (hit && hits_q != '1) hits_q <= hits_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign p1_paddle_x   = paddle_q;
  assign p1_paddle_y   = 9'(PY);
  assign ball_x        = ball_x_q;
  assign ball_y        = ball_y_q;
  assign draw_start    = draw_start_q;
  assign draw_gameover = draw_gameover_q;
  assign hits          = hits_q;

endmodule

// File: tb/tb_pong_game_logic.sv
// Directed testbench for pong_game_logic: reset, start edge, paddle clamps,
// wall bounces, paddle hit/miss, and restart paths.
module tb_pong_game_logic;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_start = 1'b0;
  logic [8:0] p1_paddle_x, p1_paddle_y, ball_x, ball_y;
  logic       draw_start, draw_gameover;
  logic [7:0] hits;

  int n_tests = 0;
  int n_fail  = 0;

  pong_game_logic dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_start(btn_start),
    .p1_paddle_x(p1_paddle_x), .p1_paddle_y(p1_paddle_y),
    .ball_x(ball_x), .ball_y(ball_y),
    .draw_start(draw_start), .draw_gameover(draw_gameover), .hits(hits)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
    end
  endtask

  task automatic start_pulse();
    @(negedge clk) btn_start = 1'b1;
    @(negedge clk) btn_start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (ball_x !== 9'd245) begin n_fail++; $display("FAIL reset_ball_x got %0d want 245", ball_x); end
    n_tests++; if (ball_y !== 9'd100) begin n_fail++; $display("FAIL reset_ball_y got %0d want 100", ball_y); end
    n_tests++; if (p1_paddle_x !== 9'd225) begin n_fail++; $display("FAIL reset_paddle_x got %0d want 225", p1_paddle_x); end
    n_tests++; if (p1_paddle_y !== 9'd460) begin n_fail++; $display("FAIL reset_paddle_y got %0d want 460", p1_paddle_y); end
    n_tests++; if (draw_start !== 1'b1) begin n_fail++; $display("FAIL reset_draw_start got %0b want 1", draw_start); end
    n_tests++; if (draw_gameover !== 1'b0) begin n_fail++; $display("FAIL reset_draw_gameover got %0b want 0", draw_gameover); end
    n_tests++; if (hits !== 8'd0) begin n_fail++; $display("FAIL reset_hits got %0d want 0", hits); end
  endtask

  task automatic test_start();
    do_reset();
    @(negedge clk) btn_start = 1'b1;
    @(negedge clk);
    n_tests++; if (draw_start !== 1'b0) begin n_fail++; $display("FAIL start_draw_start got %0b want 0", draw_start); end
    ticks(1);
    n_tests++; if (ball_x !== 9'd247 || ball_y !== 9'd102) begin n_fail++; $display("FAIL start_first_tick got (%0d,%0d) want (247,102)", ball_x, ball_y); end
    ticks(2);
    n_tests++; if (ball_x !== 9'd251 || ball_y !== 9'd106 || draw_start !== 1'b0) begin n_fail++; $display("FAIL start_held got (%0d,%0d) ds=%0b want (251,106) ds=0", ball_x, ball_y, draw_start); end
    btn_start = 1'b0;
  endtask

  task automatic test_paddle();
    do_reset();
    start_pulse();
    btn_left = 1'b1; btn_right = 1'b1;
    ticks(3);
    n_tests++; if (p1_paddle_x !== 9'd225) begin n_fail++; $display("FAIL paddle_both got %0d want 225", p1_paddle_x); end
    btn_right = 1'b0;
    ticks(56);
    n_tests++; if (p1_paddle_x !== 9'd1) begin n_fail++; $display("FAIL paddle_left56 got %0d want 1", p1_paddle_x); end
    ticks(1);
    n_tests++; if (p1_paddle_x !== 9'd0) begin n_fail++; $display("FAIL paddle_left_clamp got %0d want 0", p1_paddle_x); end
    btn_left = 1'b0; btn_right = 1'b1;
    ticks(112);
    n_tests++; if (p1_paddle_x !== 9'd448) begin n_fail++; $display("FAIL paddle_right112 got %0d want 448", p1_paddle_x); end
    ticks(1);
    n_tests++; if (p1_paddle_x !== 9'd450) begin n_fail++; $display("FAIL paddle_right_clamp got %0d want 450", p1_paddle_x); end
    ticks(1);
    n_tests++; if (p1_paddle_x !== 9'd450 || draw_gameover !== 1'b0) begin n_fail++; $display("FAIL paddle_right_hold got %0d go=%0b want 450 go=0", p1_paddle_x, draw_gameover); end
    btn_right = 1'b0;
  endtask

  task automatic test_ball_and_miss();
    do_reset();
    start_pulse();
    ticks(122);
    n_tests++; if (ball_x !== 9'd489 || ball_y !== 9'd344) begin n_fail++; $display("FAIL ball_t122 got (%0d,%0d) want (489,344)", ball_x, ball_y); end
    ticks(1);
    n_tests++; if (ball_x !== 9'd490 || ball_y !== 9'd346) begin n_fail++; $display("FAIL ball_t123 got (%0d,%0d) want (490,346)", ball_x, ball_y); end
    ticks(1);
    n_tests++; if (ball_x !== 9'd488 || ball_y !== 9'd348) begin n_fail++; $display("FAIL ball_t124 got (%0d,%0d) want (488,348)", ball_x, ball_y); end
    ticks(50);
    n_tests++; if (ball_x !== 9'd388 || ball_y !== 9'd448 || draw_gameover !== 1'b0) begin n_fail++; $display("FAIL ball_t174 got (%0d,%0d) go=%0b want (388,448) go=0", ball_x, ball_y, draw_gameover); end
    ticks(1);
    n_tests++; if (draw_gameover !== 1'b1 || draw_start !== 1'b0) begin n_fail++; $display("FAIL miss_flags got go=%0b ds=%0b want go=1 ds=0", draw_gameover, draw_start); end
    n_tests++; if (ball_x !== 9'd388 || ball_y !== 9'd448 || p1_paddle_x !== 9'd225 || hits !== 8'd0) begin n_fail++; $display("FAIL miss_frozen got (%0d,%0d) pad=%0d hits=%0d want (388,448) pad=225 hits=0", ball_x, ball_y, p1_paddle_x, hits); end
    btn_left = 1'b1;
    ticks(3);
    btn_left = 1'b0;
    n_tests++; if (ball_x !== 9'd388 || ball_y !== 9'd448 || p1_paddle_x !== 9'd225 || draw_gameover !== 1'b1) begin n_fail++; $display("FAIL gameover_hold got (%0d,%0d) pad=%0d go=%0b want (388,448) pad=225 go=1", ball_x, ball_y, p1_paddle_x, draw_gameover); end
  endtask

  task automatic test_hit();
    do_reset();
    start_pulse();
    btn_right = 1'b1;
    ticks(36);
    btn_right = 1'b0;
    n_tests++; if (p1_paddle_x !== 9'd369) begin n_fail++; $display("FAIL hit_paddle got %0d want 369", p1_paddle_x); end
    ticks(139);
    n_tests++; if (ball_x !== 9'd386 || ball_y !== 9'd450 || hits !== 8'd1 || draw_gameover !== 1'b0) begin n_fail++; $display("FAIL hit_t175 got (%0d,%0d) hits=%0d go=%0b want (386,450) hits=1 go=0", ball_x, ball_y, hits, draw_gameover); end
    ticks(1);
    n_tests++; if (ball_x !== 9'd384 || ball_y !== 9'd448) begin n_fail++; $display("FAIL hit_t176 got (%0d,%0d) want (384,448)", ball_x, ball_y); end
  endtask

  task automatic test_gameover_restart();
    do_reset();
    start_pulse();
    ticks(175);
    n_tests++; if (draw_gameover !== 1'b1) begin n_fail++; $display("FAIL restart_pre_go got %0b want 1", draw_gameover); end
    start_pulse();
    n_tests++; if (ball_x !== 9'd245 || ball_y !== 9'd100 || p1_paddle_x !== 9'd225 || hits !== 8'd0) begin n_fail++; $display("FAIL restart_pos got (%0d,%0d) pad=%0d hits=%0d want (245,100) pad=225 hits=0", ball_x, ball_y, p1_paddle_x, hits); end
    n_tests++; if (draw_start !== 1'b1 || draw_gameover !== 1'b0) begin n_fail++; $display("FAIL restart_flags got ds=%0b go=%0b want ds=1 go=0", draw_start, draw_gameover); end
    ticks(2);
    n_tests++; if (ball_x !== 9'd245 || draw_start !== 1'b1) begin n_fail++; $display("FAIL restart_idle got x=%0d ds=%0b want x=245 ds=1", ball_x, draw_start); end
  endtask

  task automatic test_reset_mid_play();
    do_reset();
    start_pulse();
    btn_left = 1'b1;
    ticks(10);
    btn_left = 1'b0;
    n_tests++; if (p1_paddle_x !== 9'd185 || ball_x !== 9'd265) begin n_fail++; $display("FAIL midplay_pre got pad=%0d x=%0d want pad=185 x=265", p1_paddle_x, ball_x); end
    do_reset();
    n_tests++; if (ball_x !== 9'd245 || ball_y !== 9'd100 || p1_paddle_x !== 9'd225 || draw_start !== 1'b1 || draw_gameover !== 1'b0 || hits !== 8'd0) begin n_fail++; $display("FAIL midplay_reset got (%0d,%0d) pad=%0d ds=%0b go=%0b hits=%0d want (245,100) pad=225 ds=1 go=0 hits=0", ball_x, ball_y, p1_paddle_x, draw_start, draw_gameover, hits); end
  endtask

  task automatic test_start_with_tick();
    do_reset();
    @(negedge clk) begin btn_start = 1'b1; frame_tick = 1'b1; end
    @(negedge clk) begin btn_start = 1'b0; frame_tick = 1'b0; end
    n_tests++; if (ball_x !== 9'd245 || ball_y !== 9'd100 || draw_start !== 1'b0) begin n_fail++; $display("FAIL start_tick_same got (%0d,%0d) ds=%0b want (245,100) ds=0", ball_x, ball_y, draw_start); end
    ticks(1);
    n_tests++; if (ball_x !== 9'd247 || ball_y !== 9'd102) begin n_fail++; $display("FAIL start_tick_next got (%0d,%0d) want (247,102)", ball_x, ball_y); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_paddle();
    test_ball_and_miss();
    test_hit();
    test_gameover_restart();
    test_reset_mid_play();
    test_start_with_tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
